// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, frame width and
// the bit-period helper shared with the transmitter.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int clks_per_bit(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for one asynchronous input,
// with a selectable reset level.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the async input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver, mid-bit sampling, bytes handed
// out on a registered valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CPB  = clks_per_bit(CLK_FREQ, BAUD);
  localparam int CW   = $clog2(CPB);
  localparam int HALF = CPB / 2;

  if (CPB < 4) begin : g_cpb_check
    $error("uart_rx: CLKS_PER_BIT must be >= 4");
  end

  uart_state_t          state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2:0]           bit_idx, bit_n;
  logic [DATA_BITS-1:0] shreg, sh_n;
  logic [DATA_BITS-1:0] data_n;
  logic                 valid_n;
  logic                 ferr_n;
  logic                 ovr_n;
  logic                 deliver;
  logic                 rs;

  bit_sync #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rs)
  );

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= sh_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  // Frame sequencing and bit sampling.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    deliver = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rs) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CW'(HALF - 1)) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rs ? IDLE : DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          sh_n  = {rs, shreg[DATA_BITS-1:1]};
          bit_n = bit_idx + 3'd1;
          if (bit_idx == 3'(DATA_BITS - 1))
            state_n = STOP;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CW'(CPB - 1)) begin
          cnt_n = '0;
          if (rs) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      WAIT_HIGH: begin
        if (rs)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register: consume, load, or flag overrun.
  always_comb begin
    data_n  = data;
    valid_n = valid & ~ready;
    ovr_n   = 1'b0;
    if (deliver) begin
      if (valid && !ready) begin
        ovr_n = 1'b1;
      end else begin
        data_n  = shreg;
        valid_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 100 clocks per bit.
// Frames are driven on the falling clock edge.
module tb_uart_rx;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_ovr    = 0;
  int rise_cyc = -1;
  int frame_start = 0;
  logic vprev = 1'b0;
  logic [7:0] rx_q[$];

  uart_rx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    #2;
    if (valid && !vprev) rise_cyc = cyc;
    vprev = valid;
    if (valid) n_valid++;
    if (valid && ready) rx_q.push_back(data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_byte(
    input string      tag,
    input logic [7:0] exp
  );
    if (rx_q.size() == 0)
      check(tag, 32'hFFFF_FFFF, {24'h0, exp});
    else
      check(tag, {24'h0, rx_q.pop_front()}, {24'h0, exp});
  endtask

  task automatic send_frame(
    input logic [7:0] b,
    input logic       stop
  );
    rx = 1'b0;
    frame_start = cyc;
    repeat (100) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (100) @(negedge clk);
    end
    rx = stop;
    repeat (100) @(negedge clk);
  endtask

  int v0, f0, o0, st;

  initial begin
    rx    = 1'b1;
    ready = 1'b1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_data", {24'h0, data}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_ferr", {31'h0, frame_err}, 32'h0);
    check("rst_ovr", {31'h0, overrun}, 32'h0);

    v0 = n_valid; f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hA5, 1'b1);
    st = frame_start;
    repeat (20) @(negedge clk);
    expect_byte("a5_data", 8'hA5);
    check("a5_latency", rise_cyc - st, 953);
    check("a5_vcycles", n_valid - v0, 1);
    check("a5_ferr", n_ferr - f0, 0);
    check("a5_ovr", n_ovr - o0, 0);

    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check("glitch_valid", n_valid - v0, 0);
    check("glitch_ferr", n_ferr - f0, 0);
    send_frame(8'h3C, 1'b1);
    repeat (20) @(negedge clk);
    expect_byte("after_glitch", 8'h3C);

    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    repeat (2000) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("break_ferr", n_ferr - f0, 1);
    check("break_valid", n_valid - v0, 0);
    send_frame(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    expect_byte("after_break", 8'h55);

    ready = 1'b0;
    o0 = n_ovr;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    repeat (10) @(negedge clk);
    check("ovr_valid", {31'h0, valid}, 32'h1);
    check("ovr_data", {24'h0, data}, 32'h11);
    check("ovr_pulse", n_ovr - o0, 1);
    ready = 1'b1;
    repeat (3) @(negedge clk);
    expect_byte("ovr_consume", 8'h11);
    check("ovr_drop", {31'h0, valid}, 32'h0);

    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (450) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'h0, data}, 32'h0);
    check("midrst_valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    check("midrst_noq", rx_q.size(), 0);
    send_frame(8'h81, 1'b1);
    repeat (20) @(negedge clk);
    expect_byte("after_rst", 8'h81);

    f0 = n_ferr; o0 = n_ovr;
    for (int i = 0; i < 10; i++)
      send_frame(8'(i), 1'b1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 10; i++)
      expect_byte($sformatf("b2b_%0d", i), 8'(i));
    check("b2b_ferr", n_ferr - f0, 0);
    check("b2b_ovr", n_ovr - o0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
